// File: rtl/slp_ctrl_pkg.sv
// Shared definitions for the perceptron training sequencer.
//   - Table/datapath widths for the sequencer, its interface and its sample RAM.
//   - ctrl_state_t : sequencer FSM states.
//   - sample_t     : one table entry {input vector, expected output}.
//   - last_index() : turns a requested samples-per-epoch count into the
//                    index of the last sample, after range correction.
package slp_ctrl_pkg;

  localparam int IN          = 4;   // perceptron inputs
  localparam int I_PREC      = 4;   // bits per input element
  localparam int O_PREC      = 5;   // bits of slp output / target
  localparam int R_PREC      = 4;   // learning-rate bits
  localparam int DEPTH       = 16;  // sample table entries (power of two)
  localparam int EPOCH_W     = 8;   // epoch counter bits
  localparam int SLP_OUT_LAT = 0;   // default slp inference latency

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;  // holds 0..DEPTH
  localparam int VEC_W  = IN * I_PREC;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESENT   = 3'd1,
    ST_CHECK     = 3'd2,
    ST_TRAIN     = 3'd3,
    ST_EPOCH_END = 3'd4,
    ST_DONE      = 3'd5
  } ctrl_state_t;

  typedef struct packed {
    logic [VEC_W-1:0]  in;
    logic [O_PREC-1:0] target;
  } sample_t;

  // A request of 0 samples still runs one; anything past the table size
  // runs the whole table.
  function automatic logic [ADDR_W-1:0] last_index(input logic [CNT_W-1:0] n);
    if (n == '0)             return '0;
    if (n > CNT_W'(DEPTH))   return ADDR_W'(DEPTH - 1);
    return ADDR_W'(n - CNT_W'(1));
  endfunction

endpackage

// File: rtl/slp_train_ctrl_if.sv
// Host and perceptron-side signal bundle of the training sequencer.
//   master : the sequencer (drives slp_* bus and status, reads config/table).
//   slave  : the environment (host + slp; drives config/table and slp_out).
interface slp_train_ctrl_if;
  import slp_ctrl_pkg::*;

  // sample table write port
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [VEC_W-1:0]    wr_in;
  logic [O_PREC-1:0]   wr_target;
  // run configuration and control
  logic [CNT_W-1:0]    n_samples;
  logic [EPOCH_W-1:0]  max_epoch;
  logic [R_PREC-1:0]   rate_cfg;
  logic                start;
  logic                abort;
  // perceptron bus
  logic [VEC_W-1:0]    slp_in;
  logic [O_PREC-1:0]   slp_train;
  logic [R_PREC-1:0]   slp_rate;
  logic                slp_t_en;
  logic [O_PREC-1:0]   slp_out;
  // status
  logic                busy;
  logic                done;
  logic                converged;
  logic [EPOCH_W-1:0]  epoch_cnt;
  logic [CNT_W-1:0]    err_cnt;

  modport master (
    input  wr_en, wr_addr, wr_in, wr_target,
    input  n_samples, max_epoch, rate_cfg, start, abort,
    input  slp_out,
    output slp_in, slp_train, slp_rate, slp_t_en,
    output busy, done, converged, epoch_cnt, err_cnt
  );

  modport slave (
    output wr_en, wr_addr, wr_in, wr_target,
    output n_samples, max_epoch, rate_cfg, start, abort,
    output slp_out,
    input  slp_in, slp_train, slp_rate, slp_t_en,
    input  busy, done, converged, epoch_cnt, err_cnt
  );

endinterface

// File: rtl/slp_sample_ram.sv
// Sample/target table: DEPTH entries of sample_t, one write port,
// asynchronous read.
//   clk     : clock
//   we_i    : write strobe
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i (combinational)
module slp_sample_ram
  import slp_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  sample_t           wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output sample_t           rdata_o
);

  // NOTE: storage arrays get no reset; contents are only meaningful after
  // the host writes them, and a reset port would prevent RAM inference.
  sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slp_train_ctrl.sv
// Training sequencer for the single-layer perceptron. Replays the sample
// table epoch by epoch: per sample it presents the input/target, compares
// slp_out with the target, and strobes slp_t_en for one cycle on mismatch.
// Stops on a zero-error epoch, at the epoch limit, or on abort.
//   clk   : clock
//   reset : synchronous, active high
//   bus   : slp_train_ctrl_if.master (table write, config, slp bus, status)
module slp_train_ctrl
  import slp_ctrl_pkg::*;
#(
  parameter int OUT_LAT = SLP_OUT_LAT
) (
  input  logic             clk,
  input  logic             reset,
  slp_train_ctrl_if.master bus
);

  localparam int LAT_W    = 8;
  localparam int LAT_LAST = (OUT_LAT > 0) ? OUT_LAT - 1 : 0;
  // With a combinational slp the settle state is skipped entirely.
  localparam ctrl_state_t SAMPLE_ENTRY = (OUT_LAT == 0) ? ST_CHECK : ST_PRESENT;

  ctrl_state_t         state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [EPOCH_W-1:0]  max_ep_q, max_ep_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [R_PREC-1:0]   rate_q, rate_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                conv_q, conv_d;
  logic                mis_q, mis_d;
  logic [LAT_W-1:0]    lat_q, lat_d;

  sample_t wr_sample, cur;
  logic    table_we;
  logic    sample_active;

  // Table is frozen while a run is in progress.
  assign table_we  = bus.wr_en && (state_q == ST_IDLE);
  assign wr_sample = '{in: bus.wr_in, target: bus.wr_target};

  slp_sample_ram u_ram (
    .clk     (clk),
    .we_i    (table_we),
    .waddr_i (bus.wr_addr),
    .wdata_i (wr_sample),
    .raddr_i (idx_q),
    .rdata_o (cur)
  );

  always_comb begin
    // NOTE: every next-state variable takes its hold value first so no path
    // through the case statement can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    max_ep_d = max_ep_q;
    epoch_d  = epoch_q;
    rate_d   = rate_q;
    run_d    = run_q;
    err_d    = err_q;
    conv_d   = conv_q;
    mis_d    = mis_q;
    lat_d    = lat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          last_d   = last_index(bus.n_samples);
          max_ep_d = (bus.max_epoch == '0) ? EPOCH_W'(1) : bus.max_epoch;
          rate_d   = bus.rate_cfg;
          epoch_d  = '0;
          err_d    = '0;
          conv_d   = 1'b0;
          run_d    = '0;
          idx_d    = '0;
          lat_d    = '0;
          state_d  = SAMPLE_ENTRY;
        end
      end

      ST_PRESENT: begin
        if (lat_q == LAT_W'(LAT_LAST)) state_d = ST_CHECK;
        else                           lat_d   = lat_q + LAT_W'(1);
      end

      ST_CHECK: begin
        mis_d = (bus.slp_out != cur.target);
        if (mis_d) run_d = run_q + CNT_W'(1);
        state_d = ST_TRAIN;
      end

      ST_TRAIN: begin
        if (idx_q == last_q) begin
          state_d = ST_EPOCH_END;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          lat_d   = '0;
          state_d = SAMPLE_ENTRY;
        end
      end

      ST_EPOCH_END: begin
        err_d   = run_q;
        epoch_d = (epoch_q == '1) ? epoch_q : epoch_q + EPOCH_W'(1);
        run_d   = '0;
        if (run_q == '0) begin
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if (epoch_q + EPOCH_W'(1) == max_ep_q) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = '0;
          lat_d   = '0;
          state_d = SAMPLE_ENTRY;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Abort pre-empts whatever the busy state was doing: results of the
    // epoch in flight are discarded and the run is reported unconverged.
    if (bus.abort && state_q != ST_IDLE) begin
      err_d   = err_q;
      epoch_d = epoch_q;
      conv_d  = 1'b0;
      state_d = (state_q == ST_DONE) ? ST_IDLE : ST_DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      max_ep_q <= '0;
      epoch_q  <= '0;
      rate_q   <= '0;
      run_q    <= '0;
      err_q    <= '0;
      conv_q   <= 1'b0;
      mis_q    <= 1'b0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      max_ep_q <= max_ep_d;
      epoch_q  <= epoch_d;
      rate_q   <= rate_d;
      run_q    <= run_d;
      err_q    <= err_d;
      conv_q   <= conv_d;
      mis_q    <= mis_d;
      lat_q    <= lat_d;
    end
  end

  // The table cannot change during a run and idx only moves on leaving
  // TRAIN, so the presented sample is stable from PRESENT through TRAIN.
  assign sample_active = (state_q == ST_PRESENT) || (state_q == ST_CHECK) ||
                         (state_q == ST_TRAIN);

  assign bus.slp_in    = sample_active ? cur.in     : '0;
  assign bus.slp_train = sample_active ? cur.target : '0;
  assign bus.slp_rate  = rate_q;
  // Abort gates the strobe in the same cycle it is raised.
  assign bus.slp_t_en  = (state_q == ST_TRAIN) && mis_q && !bus.abort;

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.converged = conv_q;
  assign bus.epoch_cnt = epoch_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_slp_train_ctrl.sv
// Self-checking bench for slp_train_ctrl. The perceptron is a stub:
//   mode 0 (learner): sample k answers wrong until it has been trained
//                     lvec[k] times in this run, then answers its target.
//   mode 1          : slp_out is constant 0.
// The reference model works per epoch from those rules alone.
module tb_slp_train_ctrl;
  import slp_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slp_train_ctrl_if bus ();

  slp_train_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int                mode;
  int                lvec    [DEPTH];
  int                need    [DEPTH];
  int                trained [DEPTH];
  logic [VEC_W-1:0]  vin     [DEPTH];
  logic [O_PREC-1:0] tgt     [DEPTH];
  int                ten_total = 0;
  int                ten_other = 0;

  // Low input nibble carries the sample index in learner mode.
  assign bus.slp_out = (mode == 1) ? '0 :
                       (trained[bus.slp_in[ADDR_W-1:0]] >= need[bus.slp_in[ADDR_W-1:0]]) ?
                         bus.slp_train : ~bus.slp_train;

  always @(posedge clk) begin
    if (bus.slp_t_en) begin
      trained[bus.slp_in[ADDR_W-1:0]] <= trained[bus.slp_in[ADDR_W-1:0]] + 1;
      ten_total <= ten_total + 1;
      if (bus.slp_train != 5'd8) ten_other <= ten_other + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_table();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      bus.wr_en     = 1'b1;
      bus.wr_addr   = ADDR_W'(k);
      bus.wr_in     = vin[k];
      bus.wr_target = tgt[k];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Learner table: unique inputs (index in low nibble), random targets.
  task automatic learner_setup(input int max_l);
    mode = 0;
    for (int k = 0; k < DEPTH; k++) begin
      vin[k]  = {12'($urandom), 4'(k)};
      tgt[k]  = 5'($urandom);
      lvec[k] = $urandom_range(0, max_l);
      need[k] = trained[k] + lvec[k];
    end
    load_table();
  endtask

  function automatic void model(input int n_cfg, input int maxep_cfg,
                                output int ep, output int err, output int conv,
                                output int cyc, output int ten);
    int n  = (n_cfg == 0) ? 1 : ((n_cfg > DEPTH) ? DEPTH : n_cfg);
    int me = (maxep_cfg == 0) ? 1 : maxep_cfg;
    ep = 0; err = 0; conv = 0; ten = 0;
    forever begin
      err = 0;
      for (int k = 0; k < n; k++)
        if ((mode == 1) ? (tgt[k] != 0) : (lvec[k] > ep)) err++;
      ten += err;
      ep++;
      if (err == 0) begin conv = 1; break; end
      if (ep >= me) break;
    end
    cyc = ep * (2 * n + 1) + 1;  // start-accept edge to the done cycle
  endfunction

  // Runs one training; returns cycles from start to done (-1 on timeout).
  task automatic do_run(input int n_cfg, input int maxep_cfg, input logic [R_PREC-1:0] rate,
                        input bit wr_busy, output int cyc);
    @(negedge clk);
    bus.n_samples = CNT_W'(n_cfg);
    bus.max_epoch = EPOCH_W'(maxep_cfg);
    bus.rate_cfg  = rate;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("run_busy", bus.busy, 1);
    check("run_rate", bus.slp_rate, rate);
    check("run_first_in", bus.slp_in, vin[0]);
    check("run_first_tgt", bus.slp_train, tgt[0]);
    if (wr_busy) begin
      bus.wr_en     = 1'b1;
      bus.wr_addr   = '0;
      bus.wr_in     = ~vin[0];
      bus.wr_target = ~tgt[0];
    end
    while (!bus.done && cyc < 5000) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      cyc++;
    end
    if (!bus.done) cyc = -1;
    @(negedge clk);
    check("run_busy_after", bus.busy, 0);
  endtask

  int cyc, e_ep, e_err, e_conv, e_cyc, e_ten, t0, o0;

  initial begin
    mode = 0;
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_in = '0; bus.wr_target = '0;
    bus.n_samples = '0; bus.max_epoch = '0; bus.rate_cfg = '0;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin lvec[k] = 0; need[k] = 0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_conv", bus.converged, 0);
    check("rst_epoch", bus.epoch_cnt, 0);
    check("rst_err", bus.err_cnt, 0);
    check("rst_t_en", bus.slp_t_en, 0);
    check("rst_slp_in", bus.slp_in, 0);

    // All samples already correct: one epoch, converged, done 34 cycles on.
    learner_setup(0);
    t0 = ten_total;
    do_run(16, 10, 4'd3, 1'b0, cyc);
    check("match_cycles", cyc, 34);
    check("match_conv", bus.converged, 1);
    check("match_epoch", bus.epoch_cnt, 1);
    check("match_err", bus.err_cnt, 0);
    check("match_t_en", ten_total - t0, 0);

    // Reset pulse during CHECK of sample 2, then a normal full epoch.
    @(negedge clk);
    bus.n_samples = 5'd16; bus.max_epoch = 8'd10; bus.rate_cfg = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_conv", bus.converged, 0);
    check("mid_rst_rate", bus.slp_rate, 0);
    check("mid_rst_train", bus.slp_train, 0);
    check("mid_rst_t_en", bus.slp_t_en, 0);
    do_run(16, 10, 4'd5, 1'b0, cyc);
    check("post_rst_cycles", cyc, 34);
    check("post_rst_conv", bus.converged, 1);

    // Constant-zero slp with an AND table: only sample 15 ever mismatches.
    mode = 1;
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < IN; i++) vin[k][i*I_PREC +: I_PREC] = k[i] ? 4'b1000 : 4'b0000;
      tgt[k] = (k == DEPTH - 1) ? 5'b01000 : 5'b00000;
    end
    load_table();
    t0 = ten_total; o0 = ten_other;
    model(16, 3, e_ep, e_err, e_conv, e_cyc, e_ten);
    do_run(16, 3, 4'd1, 1'b0, cyc);
    check("and_cycles", cyc, e_cyc);
    check("and_t_en_total", ten_total - t0, 3);
    check("and_t_en_other", ten_other - o0, 0);
    check("and_err", bus.err_cnt, 1);
    check("and_epoch", bus.epoch_cnt, 3);
    check("and_conv", bus.converged, 0);

    // Abort in TRAIN of sample 5, epoch 0; every sample mismatches here.
    for (int k = 0; k < DEPTH; k++) tgt[k] = 5'd3;
    load_table();
    @(negedge clk);
    bus.n_samples = 5'd16; bus.max_epoch = 8'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort_pre_t_en", bus.slp_t_en, 1);
    bus.abort = 1'b1;
    #1;
    check("abort_t_en", bus.slp_t_en, 0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_done", bus.done, 1);
    check("abort_conv", bus.converged, 0);
    check("abort_epoch", bus.epoch_cnt, 0);
    check("abort_err", bus.err_cnt, 0);
    @(negedge clk);
    check("abort_busy", bus.busy, 0);

    // Start and abort together in IDLE: start is dropped.
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_busy", bus.busy, 0);

    // Writes while busy are ignored; n_samples=0 runs one sample per epoch.
    learner_setup(0);
    do_run(0, 1, 4'd2, 1'b1, cyc);
    check("n0_cycles", cyc, 4);
    do_run(0, 1, 4'd2, 1'b0, cyc);  // first-sample checks confirm the table
    check("n0_again_cycles", cyc, 4);
    do_run(20, 1, 4'd2, 1'b0, cyc);
    check("n20_cycles", cyc, 34);

    // Randomised runs against the epoch-level model.
    for (int t = 0; t < 8; t++) begin
      int n_cfg, me_cfg;
      n_cfg  = $urandom_range(0, 20);
      me_cfg = $urandom_range(0, 6);
      learner_setup(4);
      model(n_cfg, me_cfg, e_ep, e_err, e_conv, e_cyc, e_ten);
      t0 = ten_total;
      do_run(n_cfg, me_cfg, 4'($urandom), 1'b0, cyc);
      check("rnd_cycles", cyc, e_cyc);
      check("rnd_epoch", bus.epoch_cnt, e_ep);
      check("rnd_err", bus.err_cnt, e_err);
      check("rnd_conv", bus.converged, e_conv);
      check("rnd_t_en", ten_total - t0, e_ten);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slp_train_ctrl.md
Name: slp_train_ctrl

Overview:
- Training sequencer for the single-layer perceptron (`slp`). Holds a small sample/target table and replays it epoch by epoch.
- Per sample it drives `slp` inputs, runs an inference check, then issues a one-cycle train strobe on mismatch.
- Counts per-epoch errors and stops on convergence (zero-error epoch) or at the epoch limit.
- Replaces the hand-written epoch loops in unit benches and is the on-chip trainer for system integration.

Parameters:
- IN, 4, number of perceptron inputs.
- I_PREC, 4, bit width of each input element.
- O_PREC, 5, bit width of `slp` output and target.
- R_PREC, 4, learning-rate width.
- DEPTH, 16, sample table entries (power of two).
- EPOCH_W, 8, epoch counter width.
- OUT_LAT, 0, `slp` inference latency in cycles (0 = combinational out).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- wr_en, in, 1, sample table write strobe; ignored while busy.
- wr_addr, in, log2(DEPTH), write address.
- wr_in, in, IN*I_PREC, sample input vector.
- wr_target, in, O_PREC, expected output for the sample.
- n_samples, in, log2(DEPTH)+1, samples per epoch (1..DEPTH); latched at start.
- max_epoch, in, EPOCH_W, epoch limit (0 treated as 1); latched at start.
- rate_cfg, in, R_PREC, learning rate; latched at start.
- start, in, 1, begin training; ignored while busy.
- abort, in, 1, stop after the current cycle.
- slp_in, out, IN*I_PREC, to `slp.in`.
- slp_train, out, O_PREC, to `slp.train`.
- slp_rate, out, R_PREC, to `slp.rate`.
- slp_t_en, out, 1, to `slp.t_en`.
- slp_out, in, O_PREC, from `slp.out`.
- busy, out, 1, high from start accept until DONE exit.
- done, out, 1, one-cycle pulse at end of training.
- converged, out, 1, sticky until next start: last epoch had zero errors.
- epoch_cnt, out, EPOCH_W, completed epochs.
- err_cnt, out, log2(DEPTH)+1, mismatch count of the last completed epoch.

Behaviour:
- **Reset values:** all outputs 0, FSM in IDLE. Sample table contents are not reset. Reset mid-run returns to IDLE in the next cycle with `slp_t_en`=0.
- **States:** IDLE, PRESENT, CHECK, TRAIN, EPOCH_END, DONE.
- **IDLE:** `wr_en` writes table[wr_addr]. On `start`, latch the config, clear epoch/err/converged, set sample index to 0, go to PRESENT.
- **PRESENT:** drive `slp_in`/`slp_train` from table[idx] and `slp_rate`=rate_cfg. Lasts OUT_LAT cycles, then go to CHECK; with OUT_LAT=0 it is skipped (IDLE/TRAIN go directly to CHECK). `slp_in`/`slp_train` hold stable from PRESENT through TRAIN.
- **CHECK (1 cycle):** mismatch = (slp_out != target). Increment the running error count if mismatch. Go to TRAIN.
- **TRAIN (1 cycle):**
  - `slp_t_en` = registered mismatch; never asserted in any other state.
  - If idx == n_samples-1, go to EPOCH_END; else idx++ and go to PRESENT/CHECK.
- **Sample timing:** each sample takes exactly OUT_LAT+2 cycles, regardless of match.
- **EPOCH_END (1 cycle):**
  - err_cnt <= running count; epoch_cnt++; running count cleared.
  - If running count == 0, set converged and go to DONE.
  - Else if epoch_cnt+1 == max_epoch, go to DONE.
  - Else set idx=0 and continue.
  - epoch_cnt saturates at all-ones.
- **DONE (1 cycle):** `done`=1, busy falls next cycle, return to IDLE.
- **Abort:** in any busy state, force `slp_t_en`=0 immediately (combinational gate) and go to DONE. converged=0, and err_cnt keeps its last completed value.
- **Precedence:** `start` and `abort` in the same IDLE cycle: abort wins and start is dropped. `wr_en` with `start`: the write completes and start proceeds using the new data.
- **Out-of-range n_samples:** 0 is treated as 1; values above DEPTH are clamped to DEPTH.

Decomposition:
- Package `slp_ctrl_pkg`: state enum `ctrl_state_t`, and a struct `sample_t {in, target}` parameterised through localparams.
- Sub-module `slp_sample_ram`: single-write, async-read DEPTH x (IN*I_PREC+O_PREC) table.

Test Plan:
- **Stub `slp_out` always equal to target, N=16, OUT_LAT=0:** converged=1, epoch_cnt=1, err_cnt=0, `done` pulse 34 cycles after start, `slp_t_en` never high.
- **Stub `slp_out` constant 0, AND targets (1.0 = 5'b01000 only for sample 15), max_epoch=3:** `slp_t_en` high only during sample-15 TRAIN each epoch, err_cnt=1, epoch_cnt=3, converged=0.
- **Real FXP `slp` (I 4/3 unsigned, W 5/3 signed), AND table, rate=4'b0001, max_epoch=100:** converged=1 before epoch 100, and a final pass shows out==target for all 16 samples.
- **Abort asserted in TRAIN of sample 5, epoch 0:** `slp_t_en` low that same cycle, `done` next cycle, converged=0, epoch_cnt=0.
- **Reset pulse mid-CHECK:** next cycle busy=0, all outputs 0; a following start runs a full epoch normally.
- **Writes while busy:** writes are ignored (table unchanged). n_samples=0 runs 1 sample per epoch; n_samples=20 clamps to 16.
